// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-nibble serial ALU.
package alu_pkg;

    localparam int BCD_RADIX = 10;
    localparam int NIBBLE_W  = 4;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        ADC = 3'd1,
        SUB = 3'd2,
        SBC = 3'd3,
        AND = 3'd4,
        OR  = 3'd5,
        XOR = 3'd6,
        CP  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } alu_state_t;

    function automatic logic uses_carry_in(input alu_op_t op);
        return (op == ADC) || (op == SBC);
    endfunction

    function automatic logic is_logic_op(input alu_op_t op);
        return (op == AND) || (op == OR) || (op == XOR);
    endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Start/busy/done handshake and operand/result bus of alu_serial.
interface alu_serial_if #(parameter int NIBBLES = 2);
    import alu_pkg::*;

    logic                      start;
    alu_op_t                   op;
    logic                      decimal;
    logic                      carry_in;
    logic [4*NIBBLES-1:0]      a;
    logic [4*NIBBLES-1:0]      b;
    logic                      busy;
    logic                      done;
    logic [4*NIBBLES-1:0]      result;
    logic                      carry;
    logic                      zero;

    modport master (
        output start, op, decimal, carry_in, a, b,
        input  busy, done, result, carry, zero
    );

    modport slave (
        input  start, op, decimal, carry_in, a, b,
        output busy, done, result, carry, zero
    );

endinterface

// File: rtl/alu_nibble.sv
// Combinational single-digit ALU slice; BCD adjust only with ALU_SERIAL_DECIMAL_EN.
module alu_nibble
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] ai,
    input  logic [NIBBLE_W-1:0] bi,
    input  logic                c,
    input  alu_op_t             op,
    input  logic                decimal,
    output logic [NIBBLE_W-1:0] ri,
    output logic                co
);

    logic [NIBBLE_W:0]        s;
    logic signed [NIBBLE_W:0] d;
    logic                     dec_en;

`ifdef ALU_SERIAL_DECIMAL_EN
    // CP always compares in binary, whatever the decimal input says.
    assign dec_en = decimal && (op != CP);
`else
    logic unused_decimal;
    assign unused_decimal = decimal;
    assign dec_en         = 1'b0;
`endif

    assign s = {1'b0, ai} + {1'b0, bi} + {{NIBBLE_W{1'b0}}, c};
    assign d = $signed({1'b0, ai}) - $signed({1'b0, bi}) - $signed({{NIBBLE_W{1'b0}}, c});

    always_comb begin
        ri = '0;
        co = 1'b0;
        case (op)
            ADD, ADC: begin
                ri = s[NIBBLE_W-1:0];
                co = s[NIBBLE_W];
                if (dec_en && (s >= (NIBBLE_W+1)'(BCD_RADIX))) begin
                    ri = s[NIBBLE_W-1:0] - NIBBLE_W'(BCD_RADIX);
                    co = 1'b1;
                end
            end
            SUB, SBC, CP: begin
                ri = d[NIBBLE_W-1:0];
                co = d[NIBBLE_W];
                if (dec_en && d[NIBBLE_W])
                    ri = d[NIBBLE_W-1:0] + NIBBLE_W'(BCD_RADIX);
            end
            AND: begin ri = ai & bi; co = c; end
            OR:  begin ri = ai | bi; co = c; end
            XOR: begin ri = ai ^ bi; co = c; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Multi-nibble ALU, one digit per clock LSB first; decimal mode needs ALU_SERIAL_DECIMAL_EN.
module alu_serial
    import alu_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    alu_serial_if.slave bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    alu_state_t        state, next_state;
    logic [IDX_W-1:0]  idx;
    logic [W-1:0]      a_q, b_q, result_q;
    alu_op_t           op_q;
    logic              dec_q, cin_q, c_run, zero_run, carry_q, zero_q;
    logic              busy, done, accept, last;
    logic [NIBBLE_W-1:0] ai, bi, ri;
    logic              co;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign last   = (idx == IDX_W'(NIBBLES - 1));
    assign ai     = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign bi     = b_q[idx*NIBBLE_W +: NIBBLE_W];

    alu_nibble u_nibble (
        .ai      (ai),
        .bi      (bi),
        .c       (c_run),
        .op      (op_q),
        .decimal (dec_q),
        .ri      (ri),
        .co      (co)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (bus.start) next_state = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = bus.start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Zero is accumulated over every nibble so CP can flag equality without touching result.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= ADD;
            dec_q    <= 1'b0;
            cin_q    <= 1'b0;
            c_run    <= 1'b0;
            zero_run <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            idx      <= '0;
            a_q      <= bus.a;
            b_q      <= bus.b;
            op_q     <= bus.op;
            dec_q    <= bus.decimal;
            cin_q    <= bus.carry_in;
            c_run    <= uses_carry_in(bus.op) ? bus.carry_in : 1'b0;
            zero_run <= 1'b1;
        end else if (state == RUN) begin
            c_run    <= co;
            zero_run <= zero_run && (ri == '0);
            if (op_q != CP)
                result_q[idx*NIBBLE_W +: NIBBLE_W] <= ri;
            if (last) begin
                idx     <= '0;
                carry_q <= is_logic_op(op_q) ? cin_q : co;
                zero_q  <= zero_run && (ri == '0);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial at NIBBLES = 1, 2 and 4; expectations follow ALU_SERIAL_DECIMAL_EN.
module tb_alu_serial;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic        carry;
        logic        zero;
        string       tag;
    } exp_t;

`ifdef ALU_SERIAL_DECIMAL_EN
    localparam logic [15:0] E_ADD_DEC = 16'h0085;
    localparam logic [15:0] E_SBC_DEC = 16'h0014;
    localparam logic [15:0] E_ADC_DEC = 16'h0000;
    localparam logic        C_ADC_DEC = 1'b1;
    localparam logic        Z_ADC_DEC = 1'b1;
`else
    localparam logic [15:0] E_ADD_DEC = 16'h007F;
    localparam logic [15:0] E_SBC_DEC = 16'h001A;
    localparam logic [15:0] E_ADC_DEC = 16'h009A;
    localparam logic        C_ADC_DEC = 1'b0;
    localparam logic        Z_ADC_DEC = 1'b0;
`endif

    logic        clk;
    logic        rst1, rst2, rst4;
    logic        start1, start2, start4;
    alu_op_t     tbOp;
    logic        tbDec, tbCin;
    logic [15:0] tbA, tbB;

    int nChecks = 0;
    int nFails  = 0;
    int doneCnt1 = 0, doneCnt2 = 0, doneCnt4 = 0;
    exp_t q1[$], q2[$], q4[$];

    alu_serial_if #(.NIBBLES(1)) bus1 ();
    alu_serial_if #(.NIBBLES(2)) bus2 ();
    alu_serial_if #(.NIBBLES(4)) bus4 ();

    assign bus1.start = start1;  assign bus1.op = tbOp;  assign bus1.decimal = tbDec;
    assign bus1.carry_in = tbCin; assign bus1.a = tbA[3:0];  assign bus1.b = tbB[3:0];
    assign bus2.start = start2;  assign bus2.op = tbOp;  assign bus2.decimal = tbDec;
    assign bus2.carry_in = tbCin; assign bus2.a = tbA[7:0];  assign bus2.b = tbB[7:0];
    assign bus4.start = start4;  assign bus4.op = tbOp;  assign bus4.decimal = tbDec;
    assign bus4.carry_in = tbCin; assign bus4.a = tbA;       assign bus4.b = tbB;

    alu_serial #(.NIBBLES(1)) u1 (.clk(clk), .reset(rst1), .bus(bus1));
    alu_serial #(.NIBBLES(2)) u2 (.clk(clk), .reset(rst2), .bus(bus2));
    alu_serial #(.NIBBLES(4)) u4 (.clk(clk), .reset(rst4), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic busyOf(input int n);
        case (n)
            1:       return bus1.busy;
            2:       return bus2.busy;
            default: return bus4.busy;
        endcase
    endfunction

    function automatic logic doneOf(input int n);
        case (n)
            1:       return bus1.done;
            2:       return bus2.done;
            default: return bus4.done;
        endcase
    endfunction

    task automatic setStart(input int n, input logic v);
        case (n)
            1:       start1 = v;
            2:       start2 = v;
            default: start4 = v;
        endcase
    endtask

    task automatic pushExp(input int n, input logic [15:0] r, input logic c, input logic z, input string tag);
        exp_t e;
        e.res = r; e.carry = c; e.zero = z; e.tag = tag;
        case (n)
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q4.push_back(e);
        endcase
    endtask

    task automatic waitDone(input int n, input string tag, output int lat);
        lat = 1;
        while (!doneOf(n) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!doneOf(n)) checkOutput({tag, " done timeout"}, 32'd0, 32'd1);
    endtask

    // One isolated operation: launches from IDLE, checks handshake timing, returns once back in IDLE.
    task automatic applyStimulus(input int n, input alu_op_t op, input logic dec, input logic cin,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] expRes, input logic expC, input logic expZ,
                                 input string tag);
        int lat;
        pushExp(n, expRes, expC, expZ, tag);
        tbOp = op; tbDec = dec; tbCin = cin; tbA = a; tbB = b;
        setStart(n, 1'b1);
        @(posedge clk); #1;
        setStart(n, 1'b0);
        tbA = ~a; tbB = ~b; tbCin = ~cin; tbDec = ~dec; tbOp = XOR;
        checkOutput({tag, " busy cycle1"}, 32'(busyOf(n)), 32'd1);
        waitDone(n, tag, lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'(n + 1));
        checkOutput({tag, " busy in done"}, 32'(busyOf(n)), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus1.done) begin
            doneCnt1++;
            if (q1.size() == 0) checkOutput("n1 unexpected done", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                checkOutput({e.tag, " result"}, 32'(bus1.result), 32'(e.res));
                checkOutput({e.tag, " carry"}, 32'(bus1.carry), 32'(e.carry));
                checkOutput({e.tag, " zero"}, 32'(bus1.zero), 32'(e.zero));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus2.done) begin
            doneCnt2++;
            if (q2.size() == 0) checkOutput("n2 unexpected done", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                checkOutput({e.tag, " result"}, 32'(bus2.result), 32'(e.res));
                checkOutput({e.tag, " carry"}, 32'(bus2.carry), 32'(e.carry));
                checkOutput({e.tag, " zero"}, 32'(bus2.zero), 32'(e.zero));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus4.done) begin
            doneCnt4++;
            if (q4.size() == 0) checkOutput("n4 unexpected done", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                checkOutput({e.tag, " result"}, 32'(bus4.result), 32'(e.res));
                checkOutput({e.tag, " carry"}, 32'(bus4.carry), 32'(e.carry));
                checkOutput({e.tag, " zero"}, 32'(bus4.zero), 32'(e.zero));
            end
        end
    end

    initial begin
        int lat;
        int cntSnap;
        rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
        start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        tbOp = ADD; tbDec = 1'b0; tbCin = 1'b0; tbA = '0; tbB = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset n1 state", {bus1.busy, bus1.done, bus1.carry, bus1.zero, 28'(bus1.result)}, 32'd0);
        checkOutput("reset n2 state", {bus2.busy, bus2.done, bus2.carry, bus2.zero, 28'(bus2.result)}, 32'd0);
        checkOutput("reset n4 state", {bus4.busy, bus4.done, bus4.carry, bus4.zero, 28'(bus4.result)}, 32'd0);
        rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1, ADD, 1'b0, 1'b0, 16'h0007, 16'h0009, 16'h0000, 1'b1, 1'b1, "n1 add 7+9");

        applyStimulus(2, ADD, 1'b1, 1'b0, 16'h0047, 16'h0038, E_ADD_DEC, 1'b0, 1'b0, "n2 add dec");
        applyStimulus(2, SBC, 1'b1, 1'b1, 16'h0020, 16'h0005, E_SBC_DEC, 1'b0, 1'b0, "n2 sbc dec");
        applyStimulus(2, ADC, 1'b1, 1'b1, 16'h0099, 16'h0000, E_ADC_DEC, C_ADC_DEC, Z_ADC_DEC, "n2 adc dec");
        applyStimulus(2, ADD, 1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0000, 1'b1, 1'b1, "n2 add ripple");
        applyStimulus(2, SUB, 1'b0, 1'b1, 16'h0030, 16'h0001, 16'h002F, 1'b0, 1'b0, "n2 sub bin");
        applyStimulus(2, OR,  1'b0, 1'b1, 16'h00A0, 16'h0005, 16'h00A5, 1'b1, 1'b0, "n2 or");
        applyStimulus(2, AND, 1'b0, 1'b0, 16'h00F0, 16'h000F, 16'h0000, 1'b0, 1'b1, "n2 and");
        applyStimulus(2, ADD, 1'b0, 1'b0, 16'h0055, 16'h0000, 16'h0055, 1'b0, 1'b0, "n2 preload");
        applyStimulus(2, CP,  1'b1, 1'b0, 16'h0012, 16'h0012, 16'h0055, 1'b0, 1'b1, "n2 cp equal");
        applyStimulus(2, CP,  1'b0, 1'b0, 16'h0011, 16'h0012, 16'h0055, 1'b1, 1'b0, "n2 cp less");

        applyStimulus(4, XOR, 1'b0, 1'b1, 16'hF0F0, 16'hFFFF, 16'h0F0F, 1'b1, 1'b0, "n4 xor");
        applyStimulus(4, SBC, 1'b0, 1'b1, 16'h1000, 16'h0001, 16'h0FFE, 1'b0, 1'b0, "n4 sbc bin");

        // A second start mid-run must neither restart nor queue another operation.
        cntSnap = doneCnt4;
        pushExp(4, 16'h2345, 1'b0, 1'b0, "n4 ignore start");
        tbOp = ADD; tbDec = 1'b0; tbCin = 1'b0; tbA = 16'h1234; tbB = 16'h1111;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        tbOp = SUB; tbA = 16'h0000; tbB = 16'h0001;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("n4 single done pulse", 32'(doneCnt4 - cntSnap), 32'd1);

        // Start held through DONE chains straight into the next run.
        pushExp(4, 16'h0003, 1'b0, 1'b0, "n4 b2b first");
        pushExp(4, 16'hFFFF, 1'b1, 1'b0, "n4 b2b second");
        tbOp = ADD; tbA = 16'h0001; tbB = 16'h0002;
        start4 = 1'b1;
        @(posedge clk); #1;
        waitDone(4, "n4 b2b first", lat);
        tbOp = SUB; tbA = 16'h0000; tbB = 16'h0001;
        @(posedge clk); #1;
        start4 = 1'b0;
        checkOutput("n4 b2b no idle", 32'(busyOf(4)), 32'd1);
        waitDone(4, "n4 b2b second", lat);
        checkOutput("n4 b2b latency", 32'(lat), 32'd5);
        @(posedge clk); #1;

        // Abort mid-run: everything clears and the aborted op never completes.
        cntSnap = doneCnt4;
        tbOp = ADD; tbA = 16'h1111; tbB = 16'h2222;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        checkOutput("n4 abort busy", 32'(bus4.busy), 32'd0);
        checkOutput("n4 abort done", 32'(bus4.done), 32'd0);
        checkOutput("n4 abort result", 32'(bus4.result), 32'd0);
        checkOutput("n4 abort carry", 32'(bus4.carry), 32'd0);
        checkOutput("n4 abort zero", 32'(bus4.zero), 32'd0);
        rst4 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("n4 abort no done", 32'(doneCnt4 - cntSnap), 32'd0);

        checkOutput("n1 queue drained", 32'(q1.size()), 32'd0);
        checkOutput("n2 queue drained", 32'(q2.size()), 32'd0);
        checkOutput("n4 queue drained", 32'(q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
